// File: rtl/calc_pkg.sv
// Shared opcode and FSM encodings for the calculator's core sequencing controllers.
package calc_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DRAIN  = 3'd3,
    S_ERR    = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  function automatic logic op_legal(input logic [1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/op_watchdog.sv
// Loadable saturating cycle counter; expired holds once LIMIT is reached.
module op_watchdog #(
  parameter int LIMIT = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         load,
  input  logic [$clog2(LIMIT+1)-1:0]   load_val,
  output logic                         expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)               cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (en && (cnt != LIM))  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt >= LIM);

endmodule

// File: rtl/calc_op_dispatcher.sv
// Serialises processor commands onto the shared multiplier/divider cores and
// returns one response per command, with error and hung-core protection.
module calc_op_dispatcher
  import calc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_err,
  output logic                 mul_init,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_result,
  output logic                 div_init,
  output logic [WIDTH-1:0]     div_a,
  output logic [WIDTH-1:0]     div_b,
  input  logic                 div_done,
  input  logic [WIDTH-1:0]     div_quot,
  input  logic [WIDTH-1:0]     div_rem
);

  state_e     state, state_nx;
  logic [1:0] op_q;
  logic       acc, bad_cmd, sel_done, wd_clr, wd_en, wd_exp;

  // A still-stretched DONE from either core means it is not back at start yet.
  assign cmd_ready = !rst && (state == S_IDLE) && !rsp_valid && !mul_done && !div_done;
  assign acc       = cmd_valid && cmd_ready;
  assign bad_cmd   = !op_legal(cmd_op) || ((cmd_op == OP_DIV) && (cmd_b == '0));
  assign sel_done  = (op_q == OP_DIV) ? div_done : mul_done;

  assign rsp_valid = (state == S_RESP);
  assign mul_init  = (state == S_LAUNCH) && (op_q == OP_MUL);
  assign div_init  = (state == S_LAUNCH) && (op_q == OP_DIV);

  assign wd_clr = acc || (rsp_valid && rsp_ready);
  assign wd_en  = (state == S_WAIT) || (state == S_DRAIN);

  op_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr      (wd_clr),
    .en       (wd_en),
    .load     (1'b0),
    .load_val ('0),
    .expired  (wd_exp)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (acc) state_nx = bad_cmd ? S_ERR : S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT:   if (sel_done) state_nx = S_DRAIN;
                else if (wd_exp) state_nx = S_RESP;
      S_DRAIN:  if (!sel_done || wd_exp) state_nx = S_RESP;
      S_ERR:    state_nx = S_RESP;
      S_RESP:   if (rsp_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      div_a    <= '0;
      div_b    <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        op_q <= cmd_op;
        if (cmd_op == OP_MUL) begin
          mul_a <= cmd_a;
          mul_b <= cmd_b;
        end
        if (cmd_op == OP_DIV) begin
          div_a <= cmd_a;
          div_b <= cmd_b;
        end
      end
      case (state)
        S_WAIT: begin
          if (sel_done) begin
            rsp_data <= (op_q == OP_MUL) ? mul_result : {div_rem, div_quot};
            rsp_err  <= 1'b0;
          end else if (wd_exp) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        // A core stuck with DONE high keeps its result but is flagged.
        S_DRAIN: if (sel_done && wd_exp) rsp_err <= 1'b1;
        S_ERR: begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_dispatcher.sv
// Randomised bench for calc_op_dispatcher with behavioural core models and scoreboard.
module tb_calc_op_dispatcher;
  localparam int W  = 16;
  localparam int TO = 63;

  logic           clk = 0, rst = 1;
  logic           cmd_valid = 0, cmd_ready;
  logic [1:0]     cmd_op = 0;
  logic [W-1:0]   cmd_a = 0, cmd_b = 0;
  logic           rsp_valid, rsp_ready = 0, rsp_err;
  logic [2*W-1:0] rsp_data;
  logic           mul_init, div_init, mul_done = 0, div_done = 0;
  logic [W-1:0]   mul_a, mul_b, div_a, div_b, div_quot = 0, div_rem = 0;
  logic [2*W-1:0] mul_result = 0;

  calc_op_dispatcher #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .mul_init(mul_init), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .div_init(div_init), .div_a(div_a),
    .div_b(div_b), .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic meaning of a command: product, or {remainder, quotient}, else 0.
  function automatic logic [2*W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, b);
    logic [2*W-1:0] x, y;
    x = a; y = b;
    if (op == 2'b00) return x * y;
    if (op == 2'b01 && b != 0) return {a % b, a / b};
    return '0;
  endfunction

  // Core models: DONE rises cfg_lat cycles after init, held cfg_str cycles.
  int cfg_lat = 20, cfg_str = 31;
  bit cfg_hang = 0;
  int mul_t = 0, div_t = 0, m_lat = 0, m_str = 0, d_lat = 0, d_str = 0;
  bit mul_run = 0, div_run = 0;
  logic [2*W-1:0] mr, dr;

  initial forever begin
    @(posedge clk); #2;
    if (mul_init) begin
      mul_run = !cfg_hang; mul_t = 0; m_lat = cfg_lat; m_str = cfg_str;
      mr = ref_result(2'b00, mul_a, mul_b);
    end else if (mul_run) begin
      mul_t++;
      if (mul_t >= m_lat + m_str) mul_run = 0;
    end
    mul_done   = mul_run && (mul_t >= m_lat);
    mul_result = mul_done ? mr : {$urandom, $urandom};
    if (div_init) begin
      div_run = !cfg_hang; div_t = 0; d_lat = cfg_lat; d_str = cfg_str;
      dr = ref_result(2'b01, div_a, div_b);
    end else if (div_run) begin
      div_t++;
      if (div_t >= d_lat + d_str) div_run = 0;
    end
    div_done = div_run && (div_t >= d_lat);
    {div_rem, div_quot} = div_done ? dr : {$urandom, $urandom};
  end

  bit rst_q = 1;
  initial forever begin @(posedge clk); rst_q = rst; end

  int mul_pulses = 0, div_pulses = 0;
  initial forever begin
    @(negedge clk);
    if (mul_init) mul_pulses++;
    if (div_init) div_pulses++;
  end

  // Scoreboard: one outstanding command, kind 0 = normal, 1 = rejected, 2 = hung core.
  bit busy = 0, hi_seen = 0, due = 0, sel = 0, e_err = 0, last_err = 0;
  int cyc = 0, kind = 0, low_cnt = 0, hs_count = 0;
  logic [1:0] m_op = 0;
  logic [W-1:0] m_a = 0, m_b = 0;
  logic [2*W-1:0] e_data = 0, last_data = 0;

  initial forever begin
    @(negedge clk);
    if (rst_q) busy = 0;
    if (!rst) begin
      due = 0;
      if (busy) begin
        cyc++;
        sel = (m_op == 2'b00) ? mul_done : div_done;
        if (kind == 0 && cyc >= 2) begin
          if (sel) hi_seen = 1;
          else if (hi_seen) low_cnt++;
        end
        due = (kind == 1) ? (cyc >= 2) : (kind == 2) ? (cyc >= TO + 3) : (low_cnt >= 2);
      end
      chk("rsp_valid", rsp_valid, due);
      if (due) begin
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_err", rsp_err, e_err);
      end
      chk("mul_init", mul_init, busy && kind != 1 && m_op == 2'b00 && cyc == 1);
      chk("div_init", div_init, busy && kind != 1 && m_op == 2'b01 && cyc == 1);
      if (busy && kind != 1) begin
        if (m_op == 2'b00) begin chk("mul_a", mul_a, m_a); chk("mul_b", mul_b, m_b); end
        else begin chk("div_a", div_a, m_a); chk("div_b", div_b, m_b); end
      end
      chk("cmd_ready", cmd_ready, !busy && !mul_done && !div_done);
      if (busy && rsp_valid && rsp_ready) begin
        busy = 0; last_data = rsp_data; last_err = rsp_err; hs_count++;
      end else if (cmd_valid && cmd_ready) begin
        busy = 1; cyc = 0; hi_seen = 0; low_cnt = 0;
        m_op = cmd_op; m_a = cmd_a; m_b = cmd_b;
        if (cmd_op[1] || (cmd_op == 2'b01 && cmd_b == 0)) begin kind = 1; e_data = 0; e_err = 1; end
        else if (cfg_hang) begin kind = 2; e_data = 0; e_err = 1; end
        else begin kind = 0; e_data = ref_result(cmd_op, cmd_a, cmd_b); e_err = 0; end
      end
    end
  end

  int n_cmds = 0;

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, b);
    int n = 0;
    @(posedge clk); #2;
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 300);
    chk("accept_bound", n < 300, 1);
    @(posedge clk); #2;
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_a = W'($urandom); cmd_b = W'($urandom);
    n_cmds++;
  endtask

  task automatic drain(input int hold, input bit rnd);
    int n = 0, seen = 0;
    bit hs = 0;
    while (!hs && n < 400) begin
      @(negedge clk); n++;
      hs = rsp_valid && rsp_ready;
      if (rsp_valid) seen++;
      @(posedge clk); #2;
      rsp_ready = !hs && (seen >= hold) && (!rnd || $urandom_range(0, 2) != 0);
    end
    chk("rsp_bound", hs, 1);
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] a, b,
                     input int lat, str, input bit hang, input int hold, input bit rnd);
    cfg_lat = lat; cfg_str = str; cfg_hang = hang;
    send(op, a, b);
    drain(hold, rnd);
    cfg_hang = 0;
  endtask

  int mp, dp, n;
  logic [1:0] rop;
  logic [W-1:0] ra, rb;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_inits", {mul_init, div_init}, 0);
    chk("rst_operands", {mul_a, mul_b, div_a, div_b}, 0);
    chk("rst_rsp", {rsp_data, rsp_err}, 0);
    @(posedge clk); #2; rst = 0;

    mp = mul_pulses; dp = div_pulses;
    run(2'b00, 200, 300, 20, 31, 0, 0, 0);
    chk("t1_data", last_data, 32'h0000EA60);
    chk("t1_err", last_err, 0);
    chk("t1_pulses", {mul_pulses - mp, div_pulses - dp}, {32'd1, 32'd0});

    mp = mul_pulses; dp = div_pulses;
    run(2'b01, 1000, 7, 12, 9, 0, 0, 0);
    chk("t2_data", last_data, 32'h0006008E);
    chk("t2_pulses", {mul_pulses - mp, div_pulses - dp}, {32'd0, 32'd1});

    mp = mul_pulses; dp = div_pulses;
    run(2'b01, 1234, 0, 5, 5, 0, 0, 0);
    chk("t3_dz", {last_data, last_err}, {32'd0, 1'b1});
    run(2'b10, 3, 4, 5, 5, 0, 0, 0);
    chk("t3_ill", {last_data, last_err}, {32'd0, 1'b1});
    chk("t3_pulses", {mul_pulses - mp, div_pulses - dp}, 0);

    run(2'b00, 5, 6, 5, 5, 1, 0, 0);
    chk("t4_timeout", {last_data, last_err}, {32'd0, 1'b1});
    run(2'b00, 16'hFFFF, 16'hFFFF, 3, 2, 0, 0, 0);
    chk("t4_next", last_data, 32'hFFFE0001);

    cfg_lat = 5; cfg_str = 4;
    send(2'b00, 16'h1234, 16'h0010);
    @(posedge clk); #2;
    cmd_valid = 1; cmd_op = 2'b01; cmd_a = 16'hFFFF; cmd_b = 16'h0100;
    drain(10, 0);
    chk("t5_first", last_data, 32'h00012340);
    @(negedge clk);
    chk("t5_b2b", cmd_ready, 1);
    @(posedge clk); #2; cmd_valid = 0; n_cmds++;
    drain(0, 1);
    chk("t5_second", last_data, 32'h00FF00FF);

    cfg_lat = 10; cfg_str = 8;
    send(2'b00, 7, 9);
    n = 0;
    do begin @(negedge clk); n++; end while (!mul_done && n < 100);
    chk("t6_done_bound", n < 100, 1);
    #1 rst = 1;
    @(posedge clk); #2; rst = 0;
    @(negedge clk);
    chk("t6_outs", {rsp_valid, mul_init, div_init, rsp_err, rsp_data, mul_a, mul_b}, 0);
    chk("t6_ready_low", cmd_ready, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (mul_done && n < 100);
    chk("t6_ready_back", cmd_ready, 1);
    n_cmds--;

    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 9);
      rop = (n < 4) ? 2'b00 : (n < 8) ? 2'b01 : (n == 8) ? 2'b10 : 2'b11;
      ra = W'($urandom);
      rb = (rop == 2'b01 && $urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      run(rop, ra, rb, $urandom_range(2, 20), $urandom_range(1, 31),
          !rop[1] && $urandom_range(0, 9) == 0, $urandom_range(0, 3), 1);
    end
    chk("hs_count", hs_count, n_cmds);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_op_dispatcher.md
Name: calc_op_dispatcher

Overview:
Sequencing controller between the calculator's processor-side command interface and the shared arithmetic cores: the shift-add multiplier and the divider. It accepts one command at a time, loads the operands, pulses the selected core's init, waits for its DONE, and captures the result. It then waits for the core's stretched DONE to drop, so the core is back in its start state, and returns the result through a valid/ready response handshake. It also guards against divide-by-zero, illegal opcodes and hung cores.

Parameters:
WIDTH, 16, operand width; the multiplier result is 2*WIDTH.
TIMEOUT_CYC, 1023, maximum cycles spent in WAIT plus DRAIN before an error is reported.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  dispatcher can accept a command
cmd_op  in  2  00 = multiply, 01 = divide, 10/11 = illegal
cmd_a  in  WIDTH  operand A / dividend
cmd_b  in  WIDTH  operand B / divisor
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_data  out  2*WIDTH  multiply: product; divide: {remainder, quotient}
rsp_err  out  1  qualifies rsp_data: illegal op, divide-by-zero or timeout
mul_init  out  1  one-cycle start pulse to multiplier
mul_a, mul_b  out  WIDTH  registered multiplier operands
mul_done  in  1  multiplier DONE (stretched, roughly 31 cycles)
mul_result  in  2*WIDTH  multiplier product
div_init  out  1  one-cycle start pulse to divider
div_a, div_b  out  WIDTH  registered divider operands
div_done  in  1  divider DONE (stretched)
div_quot, div_rem  in  WIDTH  divider results

Behaviour:
- Reset, applied in any state including mid-operation: state = IDLE; all outputs 0; operand registers, timeout counter and captured op cleared. The cores are not reset by this block.
- FSM states:
  - IDLE
    - cmd_ready = 1 only while rsp_valid = 0, mul_done = 0 and div_done = 0.
    - Accept on the clk edge with cmd_valid & cmd_ready; latch op, A and B.
    - Illegal op → ERR. op = divide with cmd_b = 0 → ERR. Otherwise → LAUNCH.
  - LAUNCH (1 cycle)
    - Operands are already on mul_a/mul_b or div_a/div_b; they are registered at accept and held stable until IDLE is re-entered.
    - Assert the selected *_init for exactly this one cycle; the other core's init stays 0.
    - → WAIT.
  - WAIT
    - Timeout counter increments each cycle.
    - Selected done = 1: capture result into rsp_data (multiply: mul_result; divide: {div_rem, div_quot}), rsp_err = 0, → DRAIN.
    - Counter reaches TIMEOUT_CYC: rsp_data = 0, rsp_err = 1, → RESP.
  - DRAIN
    - Counter keeps running; on selected done = 0 → RESP.
    - On timeout: keep the captured data, set rsp_err = 1, → RESP.
  - ERR (1 cycle)
    - rsp_data = 0, rsp_err = 1, no init pulse.
    - → RESP.
  - RESP
    - rsp_valid = 1; rsp_data and rsp_err held stable.
    - On rsp_valid & rsp_ready: rsp_valid → 0 next cycle, counter cleared, → IDLE.
- Exactly one outstanding command; cmd_ready = 0 in every state except IDLE.
- Latency from accept to rsp_valid:
  - Error path: 2 cycles (ERR, then RESP).
  - Normal path: 2 cycles + core compute time + DONE stretch.
- Done lines are only sampled for the selected core. A done assertion from the other core, or one outside WAIT/DRAIN, is ignored.
- The timeout counter is WIDTH-independent: clog2(TIMEOUT_CYC+1) bits, saturating, cleared on entry to LAUNCH.
- Back-to-back commands: a new cmd_valid may be accepted in the cycle after the response handshake, provided both done lines are low.

Decomposition:
- Shared package calc_pkg: opcode constants (OP_MUL = 2'b00, OP_DIV = 2'b01) and FSM state encodings (3 bits: IDLE, LAUNCH, WAIT, DRAIN, ERR, RESP). The team's other core controllers reuse these.
- One sub-module, op_watchdog: a loadable saturating counter with clear, enable and an expired flag at TIMEOUT_CYC. Instantiated once.

Test Plan:
1. Multiply, cmd_a = 200, cmd_b = 300, WIDTH = 16, core model done 20 cycles later and held 31 cycles. Required: single mul_init pulse; rsp_data = 60000 (0x0000EA60), rsp_err = 0; rsp_valid only after mul_done falls.
2. Divide, cmd_a = 1000, cmd_b = 7. Required: single div_init pulse, mul_init never asserted; rsp_data = 0x0006008E, rsp_err = 0.
3. Divide by zero (cmd_b = 0), then illegal op 2'b10. Required for each: rsp_valid 2 cycles after accept, rsp_err = 1, rsp_data = 0, no init pulse on either core.
4. Timeout, TIMEOUT_CYC = 63, mul_done tied 0. Required: rsp_valid with rsp_err = 1 and rsp_data = 0 after 64 WAIT cycles; next command accepted after the handshake.
5. Backpressure: hold rsp_ready = 0 for 10 cycles after rsp_valid while cmd_valid = 1 with a new command. Required: rsp_data/rsp_err stable, cmd_ready = 0 throughout; new command accepted the cycle after the handshake.
6. Assert rst for 1 cycle while in WAIT. Required: next cycle all outputs 0 and state IDLE; cmd_ready stays 0 until the core's done (model) returns low.
